// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and stage-register controls of the 5-stage pipe
interface pipeline_hazard_ctrl_if;
   logic        id_ex_mem_read;
   logic [4:0]  id_ex_rt;
   logic [4:0]  if_id_rs;
   logic [4:0]  if_id_rt;
   logic        if_id_uses_rt;
   logic        ex_mem_branch;
   logic        ex_mem_zero;
   logic        mem_req;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_src;
   logic        if_id_write;
   logic        if_id_flush;
   logic        id_ex_write;
   logic        id_ex_bubble;
   logic        ex_mem_write;
   logic        ex_mem_flush;
   logic        mem_wb_bubble;
   logic        mem_err;
   logic [1:0]  state;
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   modport master (
      output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
             ex_mem_branch, ex_mem_zero, mem_req, mem_ready,
      input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_err, state,
             stall_cycles, flush_count
   );

   modport slave (
      input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
             ex_mem_branch, ex_mem_zero, mem_req, mem_ready,
      output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_write, ex_mem_flush, mem_wb_bubble, mem_err, state,
             stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipe; PIPE_CTRL_PERF_EN adds perf counters
module pipeline_hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_MEM_ERR  = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_err;
   logic             load_use;
   logic             taken;
   logic             freeze;

   assign load_use = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                     ((bus.id_ex_rt == bus.if_id_rs) ||
                      (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));
   assign taken    = bus.ex_mem_branch && bus.ex_mem_zero;

   // A waiting access freezes regardless of mem_req; RUN only freezes on a fresh miss.
   always_comb begin
      freeze = 1'b0;
      case (state)
         ST_MEM_WAIT: freeze = !bus.mem_ready;
         ST_MEM_ERR:  freeze = 1'b1;
         default:     freeze = bus.mem_req && !bus.mem_ready;
      endcase
   end

   always_comb begin
      bus.pc_write      = 1'b1;
      bus.pc_src        = 1'b0;
      bus.if_id_write   = 1'b1;
      bus.if_id_flush   = 1'b0;
      bus.id_ex_write   = 1'b1;
      bus.id_ex_bubble  = 1'b0;
      bus.ex_mem_write  = 1'b1;
      bus.ex_mem_flush  = 1'b0;
      bus.mem_wb_bubble = 1'b0;
      if (rst) begin
         bus.pc_write      = 1'b0;
         bus.if_id_write   = 1'b0;
         bus.if_id_flush   = 1'b1;
         bus.id_ex_write   = 1'b0;
         bus.id_ex_bubble  = 1'b1;
         bus.ex_mem_write  = 1'b0;
         bus.ex_mem_flush  = 1'b1;
         bus.mem_wb_bubble = 1'b1;
      end else if (freeze) begin
         bus.pc_write      = 1'b0;
         bus.if_id_write   = 1'b0;
         bus.id_ex_write   = 1'b0;
         bus.ex_mem_write  = 1'b0;
         bus.mem_wb_bubble = 1'b1;
      end else if (taken) begin
         bus.pc_src        = 1'b1;
         bus.if_id_flush   = 1'b1;
         bus.id_ex_bubble  = 1'b1;
         bus.ex_mem_flush  = 1'b1;
      end else if (load_use) begin
         bus.pc_write      = 1'b0;
         bus.if_id_write   = 1'b0;
         bus.id_ex_bubble  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (bus.mem_req && !bus.mem_ready) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= CNT_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (bus.mem_ready) begin
                  state    <= ST_RUN;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  if (wait_cnt == CNT_W'(MAX_WAIT)) begin
                     state   <= ST_MEM_ERR;
                     mem_err <= 1'b1;
                  end
               end
            end
            ST_MEM_ERR: state <= ST_MEM_ERR;
            default:    state <= ST_RUN;
         endcase
      end
   end

   assign bus.state   = state;
   assign bus.mem_err = mem_err;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!bus.pc_write && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'd1;
         if (bus.pc_src && (flush_count != '1))
            flush_count <= flush_count + 16'd1;
      end
   end

   assign bus.stall_cycles = stall_cycles;
   assign bus.flush_count  = flush_count;
`else
   assign bus.stall_cycles = 32'd0;
   assign bus.flush_count  = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
   // ctl order: pc_write pc_src if_id_write if_id_flush id_ex_write id_ex_bubble ex_mem_write ex_mem_flush mem_wb_bubble
   localparam logic [8:0] C_DEF = 9'b1_0_1_0_1_0_1_0_0;
   localparam logic [8:0] C_FRZ = 9'b0_0_0_0_0_0_0_0_1;
   localparam logic [8:0] C_LU  = 9'b0_0_0_0_1_1_1_0_0;
   localparam logic [8:0] C_BR  = 9'b1_1_1_1_1_1_1_1_0;
   localparam logic [8:0] C_RST = 9'b0_0_0_1_0_1_0_1_1;

   typedef struct packed {
      logic [8:0] ctl;
      logic       err;
      logic [1:0] st;
   } exp_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   step_no = 0;
   exp_t q[$];
   exp_t e;
   exp_t o;
   logic [31:0] exp_stall;
   logic [15:0] exp_flush;

   pipeline_hazard_ctrl_if bus();

   pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic set_in(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic br,
                         input logic z, input logic mq, input logic rdy);
      bus.id_ex_mem_read = mr;
      bus.id_ex_rt       = ert;
      bus.if_id_rs       = rs;
      bus.if_id_rt       = rt;
      bus.if_id_uses_rt  = urt;
      bus.ex_mem_branch  = br;
      bus.ex_mem_zero    = z;
      bus.mem_req        = mq;
      bus.mem_ready      = rdy;
   endtask

   task automatic check_out();
      @(negedge clk);
      e = q.pop_front();
      o = {bus.pc_write, bus.pc_src, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
           bus.id_ex_bubble, bus.ex_mem_write, bus.ex_mem_flush, bus.mem_wb_bubble,
           bus.mem_err, bus.state};
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL step%0d ctl/err/st observed=%b expected=%b", step_no, o, e);
      end
      step_no++;
   endtask

   task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic z, input logic mq, input logic rdy,
                       input logic [8:0] ctl, input logic err, input logic [1:0] st);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r;
      set_in(mr, ert, rs, rt, urt, br, z, mq, rdy);
      x.ctl = ctl;
      x.err = err;
      x.st  = st;
      q.push_back(x);
      check_out();
   endtask

   initial begin
      exp_t x;
      rst = 1'b1;
      set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      x.ctl = C_RST; x.err = 1'b0; x.st = 2'd0;
      q.push_back(x);
      check_out();

      //    rst  mr   ert    rs     rt     urt  br   z    mq   rdy   ctl    err  st
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);
      step(1'b0, 1'b1, 5'd8, 5'd8,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd8, 5'd8,  5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);
      step(1'b0, 1'b1, 5'd8, 5'd3,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, 2'd0);
      step(1'b0, 1'b1, 5'd8, 5'd3,  5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);
      step(1'b0, 1'b1, 5'd0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);
      step(1'b0, 1'b1, 5'd9, 5'd9,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,  1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_DEF, 1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);

`ifdef PIPE_CTRL_PERF_EN
      exp_stall = 32'd2;
      exp_flush = 16'd1;
`else
      exp_stall = 32'd0;
      exp_flush = 16'd0;
`endif
      total++;
      assert (bus.stall_cycles === exp_stall) else begin
         bad++;
         $error("FAIL stall_cycles observed=%0d expected=%0d", bus.stall_cycles, exp_stall);
      end
      total++;
      assert (bus.flush_count === exp_flush) else begin
         bad++;
         $error("FAIL flush_count observed=%0d expected=%0d", bus.flush_count, exp_flush);
      end

      // Three-cycle memory wait released together with a held taken branch.
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C_BR,  1'b0, 2'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);

      // Memory never answers: 15 wait cycles, then sticky error until reset.
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd0);
      for (int i = 0; i < 15; i++)
         step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd1);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b1, 2'd2);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_FRZ, 1'b1, 2'd2);
      step(1'b1, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_RST, 1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_DEF, 1'b0, 2'd0);

      // Async reset in the middle of a memory wait.
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd0);
      step(1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 1'b0, 2'd1);
      step(1'b1, 1'b0, 5'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_RST, 1'b0, 2'd0);
      step(1'b0, 1'b1, 5'd5, 5'd5,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,  1'b0, 2'd0);

      total++;
      assert (q.size() === 0) else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
